// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester round-robin front end for a shared combinational ALU.
// One transaction is in flight at a time. The FSM runs IDLE -> EXEC -> RESP,
// and an unsupported op goes straight from IDLE to RESP.
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   req_valid_i/req_ready_o     per-requester request handshake (ready is combinational in IDLE)
//   req_op{0,1}_i, req_a/b{0,1}_i  per-requester op code and operands
//   rsp_valid_o/rsp_ready_i     per-requester response handshake
//   rsp_data_o, rsp_err_o       shared result and unsupported-op flag
//   alu_op_o, alu_a_o, alu_b_o  drive to the shared ALU; alu_result_i returns its result
//   busy_o                      high while a transaction is in flight
module alu_arbiter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid_i,
  output logic [1:0]       req_ready_o,
  input  logic [3:0]       req_op0_i,
  input  logic [3:0]       req_op1_i,
  input  logic [WIDTH-1:0] req_a0_i,
  input  logic [WIDTH-1:0] req_b0_i,
  input  logic [WIDTH-1:0] req_a1_i,
  input  logic [WIDTH-1:0] req_b1_i,
  output logic [1:0]       rsp_valid_o,
  input  logic [1:0]       rsp_ready_i,
  output logic [WIDTH-1:0] rsp_data_o,
  output logic             rsp_err_o,
  output logic [3:0]       alu_op_o,
  output logic [WIDTH-1:0] alu_a_o,
  output logic [WIDTH-1:0] alu_b_o,
  input  logic [WIDTH-1:0] alu_result_i,
  output logic             busy_o
);

  localparam int unsigned OPW = 4;
  localparam logic [OPW-1:0] OP_ADD = 4'b0010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  logic             last_grant;
  logic             owner;
  logic [OPW-1:0]   op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] result_q;
  logic             err_q;

  logic             grant_any;
  logic             grant_sel;
  logic [OPW-1:0]   sel_op;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;

  // Op codes the shared ALU implements
  function automatic logic op_supported(input logic [OPW-1:0] op);
    case (op)
      4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0101,
      4'b1000, 4'b1001, 4'b1010, 4'b1011: op_supported = 1'b1;
      default:                            op_supported = 1'b0;
    endcase
  endfunction

  // Round-robin grant: on contention the requester that did not win last time wins now
  always_comb begin
    grant_any = 1'b0;
    grant_sel = 1'b0;
    if (rst_n && (state == IDLE)) begin
      case (req_valid_i)
        2'b01: begin grant_any = 1'b1; grant_sel = 1'b0;        end
        2'b10: begin grant_any = 1'b1; grant_sel = 1'b1;        end
        2'b11: begin grant_any = 1'b1; grant_sel = ~last_grant; end
        default: ;
      endcase
    end
    sel_op = grant_sel ? req_op1_i : req_op0_i;
    sel_a  = grant_sel ? req_a1_i  : req_a0_i;
    sel_b  = grant_sel ? req_b1_i  : req_b0_i;
  end

  // FSM and all transaction registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      op_q       <= OP_ADD;
      a_q        <= '0;
      b_q        <= '0;
      result_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            owner      <= grant_sel;
            last_grant <= grant_sel;
            op_q       <= sel_op;
            a_q        <= sel_a;
            b_q        <= sel_b;
            if (op_supported(sel_op)) begin
              state <= EXEC;
            end else begin
              // Unsupported op skips the ALU and responds with a zero result plus error
              result_q <= '0;
              err_q    <= 1'b1;
              state    <= RESP;
            end
          end
        end
        EXEC: begin
          result_q <= alu_result_i;
          err_q    <= 1'b0;
          state    <= RESP;
        end
        RESP: begin
          // Only the owner's ready completes the response
          if (rsp_ready_i[owner]) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output decode from registered state; reset forces the idle values
  assign req_ready_o = grant_any ? (grant_sel ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_valid_o = (rst_n && (state == RESP)) ? (owner ? 2'b10 : 2'b01) : 2'b00;
  assign busy_o      = rst_n && (state != IDLE);
  assign alu_op_o    = (rst_n && (state == EXEC)) ? op_q : OP_ADD;
  assign alu_a_o     = a_q;
  assign alu_b_o     = b_q;
  assign rsp_data_o  = result_q;
  assign rsp_err_o   = err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: the bench plays the shared ALU and compares
// the DUT on every cycle against a transaction-level model (which request is in
// flight, and how many cycles have passed since it was accepted).
module tb_alu_arbiter;

  localparam int unsigned W = 32;

  logic         clk;
  logic         rst_n;
  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [3:0]   req_op0, req_op1;
  logic [W-1:0] req_a0, req_b0, req_a1, req_b1;
  logic [1:0]   rsp_valid;
  logic [1:0]   rsp_ready;
  logic [W-1:0] rsp_data;
  logic         rsp_err;
  logic [3:0]   alu_op;
  logic [W-1:0] alu_a, alu_b, alu_result;
  logic         busy;

  int checks = 0;
  int errors = 0;

  alu_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_op0_i(req_op0), .req_op1_i(req_op1),
    .req_a0_i(req_a0), .req_b0_i(req_b0), .req_a1_i(req_a1), .req_b1_i(req_b1),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_data_o(rsp_data), .rsp_err_o(rsp_err),
    .alu_op_o(alu_op), .alu_a_o(alu_a), .alu_b_o(alu_b),
    .alu_result_i(alu_result), .busy_o(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic is_sup(input logic [3:0] op);
    return op inside {4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};
  endfunction

  function automatic logic [W-1:0] alu_fn(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      4'h0: return a & b;
      4'h1: return a - b;
      4'h2: return a + b;
      4'h3: return a | b;
      4'h4: return a ^ b;
      4'h5: return ($signed(a) < $signed(b)) ? W'(1) : W'(0);
      4'h8: return (a == b) ? W'(1) : W'(0);
      4'h9: return a << b[4:0];
      4'hA: return a >> b[4:0];
      4'hB: return W'($signed(a) >>> b[4:0]);
      default: return '0;
    endcase
  endfunction

  // The bench acts as the shared combinational ALU
  always_comb alu_result = alu_fn(alu_op, alu_a, alu_b);

  // Transaction-level model
  logic         m_inflight = 1'b0;
  int           m_age = 0;
  logic         m_owner = 1'b0;
  logic         m_last = 1'b1;
  logic [3:0]   m_op = 4'h2;
  logic [W-1:0] m_a = '0, m_b = '0, m_data = '0;
  logic         m_err = 1'b0;
  logic         m_sup = 1'b1;

  // Output snapshot of the most recently stepped cycle, for literal checks
  logic [1:0]   s_ready, s_valid;
  logic [W-1:0] s_data;
  logic         s_err, s_busy;
  logic [3:0]   s_op;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: compare at negedge, advance the model, return just after posedge
  task automatic step();
    logic [1:0] e_ready, e_valid;
    logic       e_busy, e_resp;
    logic [3:0] e_op;
    @(negedge clk);
    e_ready = 2'b00; e_valid = 2'b00; e_busy = 1'b0; e_resp = 1'b0; e_op = 4'h2;
    if (rst_n) begin
      if (!m_inflight) begin
        if (req_valid == 2'b11) e_ready = m_last ? 2'b01 : 2'b10;
        else                    e_ready = req_valid;
      end else begin
        e_busy = 1'b1;
        e_resp = m_sup ? (m_age >= 2) : 1'b1;
        if (m_sup && m_age == 1) e_op = m_op;
        if (e_resp) e_valid = m_owner ? 2'b10 : 2'b01;
      end
    end
    chk("req_ready", 64'(req_ready), 64'(e_ready));
    chk("rsp_valid", 64'(rsp_valid), 64'(e_valid));
    chk("busy", 64'(busy), 64'(e_busy));
    chk("alu_op", 64'(alu_op), 64'(e_op));
    if (rst_n) begin
      chk("alu_a", 64'(alu_a), 64'(m_a));
      chk("alu_b", 64'(alu_b), 64'(m_b));
    end
    if (e_resp) begin
      chk("rsp_data", 64'(rsp_data), 64'(m_data));
      chk("rsp_err", 64'(rsp_err), 64'(m_err));
    end
    s_ready = req_ready; s_valid = rsp_valid; s_data = rsp_data;
    s_err = rsp_err; s_busy = busy; s_op = alu_op;
    if (!rst_n) begin
      m_inflight = 1'b0; m_last = 1'b1; m_a = '0; m_b = '0;
    end else if (!m_inflight) begin
      if (e_ready != 2'b00) begin
        m_inflight = 1'b1;
        m_age      = 1;
        m_owner    = e_ready[1];
        m_last     = m_owner;
        m_op       = m_owner ? req_op1 : req_op0;
        m_a        = m_owner ? req_a1 : req_a0;
        m_b        = m_owner ? req_b1 : req_b0;
        m_sup      = is_sup(m_op);
        m_data     = m_sup ? alu_fn(m_op, m_a, m_b) : '0;
        m_err      = !m_sup;
      end
    end else if (e_resp && rsp_ready[m_owner]) begin
      m_inflight = 1'b0;
    end else begin
      m_age++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int k, input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    if (k == 0) begin req_op0 = op; req_a0 = a; req_b0 = b; end
    else        begin req_op1 = op; req_a1 = a; req_b1 = b; end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 2'b00; rsp_ready = 2'b00;
    set_req(0, 4'h2, '0, '0);
    set_req(1, 4'h2, '0, '0);
    step();
    chk("rst_ready", 64'(s_ready), 64'(2'b00));
    chk("rst_valid", 64'(s_valid), 64'(2'b00));
    chk("rst_busy", 64'(s_busy), 64'(1'b0));
    chk("rst_aluop", 64'(s_op), 64'(4'b0010));
    do_reset();

    // Single ADD request
    rsp_ready = 2'b11; set_req(0, 4'h2, 32'd5, 32'd7); req_valid = 2'b01;
    step(); chk("single_ready", 64'(s_ready), 64'(2'b01));
    req_valid = 2'b00;
    step(); chk("single_exec_valid", 64'(s_valid), 64'(2'b00));
    step(); chk("single_valid", 64'(s_valid), 64'(2'b01));
            chk("single_data", 64'(s_data), 64'(32'd12));
            chk("single_err", 64'(s_err), 64'(1'b0));
    step(); chk("single_idle_busy", 64'(s_busy), 64'(1'b0));

    // Contention after reset alternates starting with requester 0
    do_reset();
    set_req(0, 4'h1, 32'd10, 32'd3);
    set_req(1, 4'h4, 32'hF0, 32'h0F);
    req_valid = 2'b11; rsp_ready = 2'b11;
    step(); chk("rr_grant0", 64'(s_ready), 64'(2'b01));
    step();
    step(); chk("rr_valid0", 64'(s_valid), 64'(2'b01));
            chk("rr_data0", 64'(s_data), 64'(32'd7));
    step(); chk("rr_grant1", 64'(s_ready), 64'(2'b10));
    step();
    step(); chk("rr_valid1", 64'(s_valid), 64'(2'b10));
            chk("rr_data1", 64'(s_data), 64'(32'hFF));
    step(); chk("rr_grant0_again", 64'(s_ready), 64'(2'b01));
    req_valid = 2'b00;
    step(); step(); step();

    // Backpressure on a held SLT response
    set_req(1, 4'h5, 32'hFFFF_FFFF, 32'd1); req_valid = 2'b10; rsp_ready = 2'b00;
    step(); chk("bp_accept", 64'(s_ready), 64'(2'b10));
    req_valid = 2'b11;
    step(); chk("bp_exec_ready", 64'(s_ready), 64'(2'b00));
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_valid", 64'(s_valid), 64'(2'b10));
      chk("bp_data", 64'(s_data), 64'(32'd1));
      chk("bp_ready", 64'(s_ready), 64'(2'b00));
      chk("bp_busy", 64'(s_busy), 64'(1'b1));
    end
    rsp_ready = 2'b10; req_valid = 2'b00;
    step(); step();

    // Unsupported op responds after one cycle with error
    set_req(0, 4'h6, 32'd3, 32'd4); req_valid = 2'b01; rsp_ready = 2'b00;
    step(); chk("unsup_accept", 64'(s_ready), 64'(2'b01));
            chk("unsup_aluop0", 64'(s_op), 64'(4'b0010));
    req_valid = 2'b00;
    step(); chk("unsup_valid", 64'(s_valid), 64'(2'b01));
            chk("unsup_data", 64'(s_data), 64'(0));
            chk("unsup_err", 64'(s_err), 64'(1'b1));
            chk("unsup_aluop1", 64'(s_op), 64'(4'b0010));
    rsp_ready = 2'b01;
    step(); step();

    // Reset while a response is pending
    set_req(0, 4'h2, 32'd1, 32'd2); set_req(1, 4'h2, 32'd3, 32'd4);
    req_valid = 2'b01; rsp_ready = 2'b00;
    step(); req_valid = 2'b00;
    step();
    step(); chk("rstresp_valid_before", 64'(s_valid), 64'(2'b01));
    rst_n = 1'b0;
    step(); chk("rstresp_valid_in", 64'(s_valid), 64'(2'b00));
    rst_n = 1'b1; req_valid = 2'b11;
    step(); chk("rstresp_valid_after", 64'(s_valid), 64'(2'b00));
            chk("rstresp_busy_after", 64'(s_busy), 64'(1'b0));
            chk("rstresp_grant0", 64'(s_ready), 64'(2'b01));
    req_valid = 2'b00; rsp_ready = 2'b11;
    step(); step(); step();

    // Non-owner ready is ignored
    set_req(1, 4'h2, 32'd9, 32'd9); req_valid = 2'b10; rsp_ready = 2'b01;
    step(); req_valid = 2'b00;
    step();
    step(); chk("nonowner_valid0", 64'(s_valid), 64'(2'b10));
    step(); chk("nonowner_valid1", 64'(s_valid), 64'(2'b10));
            chk("nonowner_busy", 64'(s_busy), 64'(1'b1));
    rsp_ready = 2'b10;
    step(); step();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      rst_n     = ($urandom_range(0, 199) != 0);
      req_valid = 2'($urandom_range(0, 3));
      rsp_ready = 2'($urandom_range(0, 3));
      for (int k = 0; k < 2; k++) begin
        if ($urandom_range(0, 1) == 0)
          set_req(k, 4'($urandom_range(0, 15)), W'($urandom_range(0, 40)), W'($urandom_range(0, 40)));
        else
          set_req(k, 4'($urandom_range(0, 15)), W'($urandom), W'($urandom));
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width in bits.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 req_valid_i  input  2  per-requester request valid; bit k = requester k.
REQ-005 req_ready_o  output  2  per-requester request accepted this cycle.
REQ-006 req_op0_i, req_op1_i  input  4 each  requested ALU Operation code.
REQ-007 req_a0_i, req_b0_i, req_a1_i, req_b1_i  input  WIDTH each  operands.
REQ-008 rsp_valid_o  output  2  per-requester response valid.
REQ-009 rsp_ready_i  input  2  per-requester response accepted.
REQ-010 rsp_data_o  output  WIDTH  result, shared by both requesters.
REQ-011 rsp_err_o  output  1  unsupported Operation code flag, qualified by rsp_valid_o.
REQ-012 alu_op_o  output  4  Operation code to shared ALU.
REQ-013 alu_a_o, alu_b_o  output  WIDTH each  operands to shared ALU.
REQ-014 alu_result_i  input  WIDTH  combinational ALU result.
REQ-015 busy_o  output  1  high whenever state is not IDLE.

Function
REQ-016 FSM states IDLE, EXEC, RESP; one transaction in flight at a time.
REQ-017 IDLE: if any req_valid_i bit set, grant exactly one requester, assert its req_ready_o bit combinationally, latch its op/a/b and owner index, go EXEC (or RESP for unsupported op).
REQ-018 req_ready_o is 2'b00 in EXEC and RESP; at most one bit set in any cycle.
REQ-019 Arbitration: round-robin via last_grant register; both valid -> grant the requester not equal to last_grant; single valid -> grant it regardless of last_grant.
REQ-020 last_grant updates to the owner on acceptance only.
REQ-021 Supported ops: 0000 AND, 0001 SUB, 0010 ADD, 0011 OR, 0100 XOR, 0101 SLT, 1000 EQ, 1001 SLL, 1010 SRL, 1011 SRA; all others unsupported.
REQ-022 Unsupported op: skip EXEC, go directly to RESP with rsp_data_o = 0 and rsp_err_o = 1.
REQ-023 EXEC lasts exactly one cycle: alu_op_o = latched op; on the closing edge capture alu_result_i into result register, rsp_err_o register = 0, go RESP.
REQ-024 Outside EXEC alu_op_o = 4'b0010 (ADD); alu_a_o/alu_b_o always drive latched operands.
REQ-025 RESP: rsp_valid_o bit of owner high, other bit low; rsp_data_o/rsp_err_o stable until handshake.
REQ-026 RESP with rsp_ready_i[owner] = 1 -> IDLE next cycle; rsp_ready_i of non-owner ignored.
REQ-027 Latency: request accepted at edge N -> rsp_valid_o high in cycle after edge N+1 (supported op) or after edge N (unsupported); max throughput one transaction per 3 cycles.
REQ-028 No new request accepted in the cycle a response handshakes; acceptance resumes in IDLE.
REQ-029 Requester dropping req_valid_i without handshake is legal; nothing latched.

Reset
REQ-030 rst_n = 0 at a rising edge: state = IDLE, last_grant = 1 (requester 0 wins first contention), latched op = 4'b0010, operands = 0, result = 0, err = 0, owner = 0.
REQ-031 Reset outputs: req_ready_o follows IDLE rule only after release; during reset req_ready_o = 0, rsp_valid_o = 0, busy_o = 0, alu_op_o = 4'b0010.
REQ-032 Reset mid-transaction (EXEC or RESP) discards it; no response is ever produced for it.

Verification
REQ-033 Single request: req0 ADD a=5 b=7, rsp_ready=1 -> req_ready_o=01 same cycle, rsp_valid_o=01 two cycles later, rsp_data_o=12, err=0.
REQ-034 Contention after reset: both valid, req0 SUB 10-3, req1 XOR F0^0F -> req0 served first (data 7), then req1 (data FF); repeat both -> req0 again only after req1, alternating.
REQ-035 Backpressure: req1 SLT a=-1 b=1, rsp_ready held 0 for 5 cycles -> rsp_valid_o=10 held, rsp_data_o=1 stable, req_ready_o=00 throughout, busy_o=1.
REQ-036 Unsupported op 0110 from req0 -> rsp_valid_o=01 one cycle after acceptance, rsp_data_o=0, rsp_err_o=1, alu_op_o never 0110.
REQ-037 Reset in RESP: rst_n low one cycle while rsp_valid_o=01 -> next cycle rsp_valid_o=00, busy_o=0; next request from both served req0 first.
REQ-038 Non-owner ready: owner req1 in RESP, rsp_ready_i=01 -> stays RESP, rsp_valid_o=10.
